// File: rtl/axis_decimator_pkg.sv
// Shared definitions for the multi-channel stream decimator: output mode
// encoding and the width-parametrised saturation helpers.
package axis_decimator_pkg;

  typedef enum logic {
    MODE_PICK = 1'b0,
    MODE_AVG  = 1'b1
  } mode_e;

  // Largest representable value for a w-bit signed or unsigned result.
  function automatic logic signed [63:0] sat_hi(input int w, input logic is_signed);
    if (is_signed) begin
      sat_hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    end else begin
      sat_hi = (64'sd1 <<< w) - 64'sd1;
    end
  endfunction

  function automatic logic signed [63:0] sat_lo(input int w, input logic is_signed);
    if (is_signed) begin
      sat_lo = -(64'sd1 <<< (w - 1));
    end else begin
      sat_lo = 64'sd0;
    end
  endfunction

  function automatic logic signed [63:0] sat_value(input logic signed [63:0] v, input int w,
                                                   input logic is_signed);
    if (v > sat_hi(w, is_signed)) begin
      sat_value = sat_hi(w, is_signed);
    end else if (v < sat_lo(w, is_signed)) begin
      sat_value = sat_lo(w, is_signed);
    end else begin
      sat_value = v;
    end
  endfunction

  function automatic logic sat_clipped(input logic signed [63:0] v, input int w,
                                       input logic is_signed);
    sat_clipped = (v > sat_hi(w, is_signed)) || (v < sat_lo(w, is_signed));
  endfunction

endpackage

// File: rtl/decim_acc_ch.sv
// One channel of the decimator datapath: sample extension, window accumulation,
// shift and saturation, plus the pick-mode width adaptation.
module decim_acc_ch
  import axis_decimator_pkg::*;
#(
  parameter int DATA_IN_WIDTH  = 12,
  parameter int DATA_OUT_WIDTH = 16,
  parameter int ACC_WIDTH      = 32,
  parameter int SIGNED         = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      accept,
  input  logic                      first,
  input  logic                      complete,
  input  logic                      mode_avg,
  input  logic [4:0]                shift,
  input  logic [DATA_IN_WIDTH-1:0]  x,
  output logic [DATA_OUT_WIDTH-1:0] result,
  output logic                      clipped
);

  localparam logic IS_SIGNED = (SIGNED != 0);

  logic                      fill_s;
  logic [ACC_WIDTH-1:0]      x_ext_s;
  logic [ACC_WIDTH-1:0]      sum_s;
  logic [ACC_WIDTH-1:0]      shifted_s;
  logic [63:0]               wide_s;
  logic [DATA_OUT_WIDTH-1:0] pick_s;
  logic [ACC_WIDTH-1:0]      acc_q, acc_d;

  assign fill_s  = IS_SIGNED ? x[DATA_IN_WIDTH-1] : 1'b0;
  assign x_ext_s = {{(ACC_WIDTH-DATA_IN_WIDTH){fill_s}}, x};
  assign sum_s   = (first ? {ACC_WIDTH{1'b0}} : acc_q) + x_ext_s;

  always_comb begin
    if (IS_SIGNED) begin
      shifted_s = $signed(sum_s) >>> shift;
    end else begin
      shifted_s = sum_s >> shift;
    end
  end

  assign wide_s = {{(64-ACC_WIDTH){IS_SIGNED & shifted_s[ACC_WIDTH-1]}}, shifted_s};

  // Narrower outputs keep the input MSBs; wider ones extend per signedness.
  generate
    if (DATA_OUT_WIDTH > DATA_IN_WIDTH) begin : g_pick_wide
      assign pick_s = {{(DATA_OUT_WIDTH-DATA_IN_WIDTH){fill_s}}, x};
    end else if (DATA_OUT_WIDTH == DATA_IN_WIDTH) begin : g_pick_same
      assign pick_s = x;
    end else begin : g_pick_narrow
      assign pick_s = x[DATA_IN_WIDTH-1 -: DATA_OUT_WIDTH];
    end
  endgenerate

  always_comb begin
    if (mode_avg) begin
      result  = DATA_OUT_WIDTH'(sat_value($signed(wide_s), DATA_OUT_WIDTH, IS_SIGNED));
      clipped = sat_clipped($signed(wide_s), DATA_OUT_WIDTH, IS_SIGNED);
    end else begin
      result  = pick_s;
      clipped = 1'b0;
    end
  end

  always_comb begin
    acc_d = acc_q;
    if (clear) begin
      acc_d = {ACC_WIDTH{1'b0}};
    end else if (accept && complete) begin
      acc_d = {ACC_WIDTH{1'b0}};
    end else if (accept) begin
      acc_d = sum_s;
    end else begin
      acc_d = acc_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= {ACC_WIDTH{1'b0}};
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/axis_decimator_mc.sv
// Multi-channel valid/ready stream decimator: window counter, per-window config
// shadows, handshake and output register around NUM_CH channel datapaths.
module axis_decimator_mc
  import axis_decimator_pkg::*;
#(
  parameter int NUM_CH         = 2,
  parameter int DATA_IN_WIDTH  = 12,
  parameter int DATA_OUT_WIDTH = 16,
  parameter int DATA_REG_WIDTH = 32,
  parameter int ACC_WIDTH      = 32,
  parameter int SIGNED         = 0
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               enable,
  input  logic                               mode,
  input  logic [DATA_REG_WIDTH-1:0]          decimate_reg,
  input  logic [4:0]                         avg_shift,
  input  logic [NUM_CH*DATA_IN_WIDTH-1:0]    in_data,
  input  logic                               in_valid,
  output logic                               in_ready,
  output logic [NUM_CH*DATA_OUT_WIDTH-1:0]   out_data,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic                               sat_flag
);

  logic [DATA_REG_WIDTH-1:0]        cnt_q, cnt_d;
  logic [DATA_REG_WIDTH-1:0]        ratio_q, ratio_d;
  mode_e                            mode_q, mode_d;
  logic [4:0]                       shift_q, shift_d;
  logic                             out_valid_q, out_valid_d;
  logic [NUM_CH*DATA_OUT_WIDTH-1:0] out_data_q, out_data_d;
  logic                             sat_q, sat_d;

  logic                             win_start_s;
  logic [DATA_REG_WIDTH-1:0]        eff_ratio_s;
  mode_e                            eff_mode_s;
  logic [4:0]                       eff_shift_s;
  logic                             in_ready_s;
  logic                             accept_s;
  logic                             complete_s;
  logic [NUM_CH*DATA_OUT_WIDTH-1:0] result_s;
  logic [NUM_CH-1:0]                clip_s;

  // The first beat of a window runs on the live config; later beats use the shadows.
  assign win_start_s = (cnt_q == {DATA_REG_WIDTH{1'b0}});
  assign eff_ratio_s = win_start_s ? decimate_reg : ratio_q;
  assign eff_mode_s  = win_start_s ? mode_e'(mode) : mode_q;
  assign eff_shift_s = win_start_s ? avg_shift : shift_q;

  assign in_ready_s = !rst && enable && (!out_valid_q || out_ready);
  assign accept_s   = in_valid && in_ready_s;
  assign complete_s = accept_s && (cnt_q == eff_ratio_s);

  generate
    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
      decim_acc_ch #(
        .DATA_IN_WIDTH  (DATA_IN_WIDTH),
        .DATA_OUT_WIDTH (DATA_OUT_WIDTH),
        .ACC_WIDTH      (ACC_WIDTH),
        .SIGNED         (SIGNED)
      ) u_acc (
        .clk      (clk),
        .rst      (rst),
        .clear    (!enable),
        .accept   (accept_s),
        .first    (win_start_s),
        .complete (complete_s),
        .mode_avg (eff_mode_s == MODE_AVG),
        .shift    (eff_shift_s),
        .x        (in_data[ch*DATA_IN_WIDTH +: DATA_IN_WIDTH]),
        .result   (result_s[ch*DATA_OUT_WIDTH +: DATA_OUT_WIDTH]),
        .clipped  (clip_s[ch])
      );
    end
  endgenerate

  always_comb begin
    cnt_d       = cnt_q;
    ratio_d     = ratio_q;
    mode_d      = mode_q;
    shift_d     = shift_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    sat_d       = sat_q;

    if (!enable) begin
      cnt_d = {DATA_REG_WIDTH{1'b0}};
    end else if (accept_s) begin
      cnt_d = complete_s ? {DATA_REG_WIDTH{1'b0}} : cnt_q + {{(DATA_REG_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end

    if (accept_s && win_start_s) begin
      ratio_d = decimate_reg;
      mode_d  = mode_e'(mode);
      shift_d = avg_shift;
    end else begin
      ratio_d = ratio_q;
      mode_d  = mode_q;
      shift_d = shift_q;
    end

    // A completion and an output handshake in the same cycle both proceed.
    if (complete_s) begin
      out_valid_d = 1'b1;
      out_data_d  = result_s;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end

    if (!enable) begin
      sat_d = 1'b0;
    end else if (complete_s && (|clip_s)) begin
      sat_d = 1'b1;
    end else begin
      sat_d = sat_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= {DATA_REG_WIDTH{1'b0}};
      ratio_q     <= {DATA_REG_WIDTH{1'b0}};
      mode_q      <= MODE_PICK;
      shift_q     <= 5'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= {(NUM_CH*DATA_OUT_WIDTH){1'b0}};
      sat_q       <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      ratio_q     <= ratio_d;
      mode_q      <= mode_d;
      shift_q     <= shift_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      sat_q       <= sat_d;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign sat_flag  = sat_q;

endmodule

// File: tb/tb_axis_decimator_mc.sv
// Directed bench for axis_decimator_mc: an unsigned default instance and a
// signed 12-bit-output instance driven by hand-computed vectors.
module tb_axis_decimator_mc;

  logic        clk;
  logic        rst;

  logic        u_enable, u_mode, u_in_valid, u_in_ready, u_out_valid, u_out_ready, u_sat;
  logic [31:0] u_dec;
  logic [4:0]  u_shift;
  logic [23:0] u_in_data;
  logic [31:0] u_out_data;

  logic        s_enable, s_mode, s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_sat;
  logic [31:0] s_dec;
  logic [4:0]  s_shift;
  logic [23:0] s_in_data;
  logic [23:0] s_out_data;

  int checks = 0;
  int errors = 0;
  bit exp_ov [8];

  axis_decimator_mc dut_u (
    .clk(clk), .rst(rst), .enable(u_enable), .mode(u_mode), .decimate_reg(u_dec),
    .avg_shift(u_shift), .in_data(u_in_data), .in_valid(u_in_valid), .in_ready(u_in_ready),
    .out_data(u_out_data), .out_valid(u_out_valid), .out_ready(u_out_ready), .sat_flag(u_sat)
  );

  axis_decimator_mc #(.DATA_OUT_WIDTH(12), .SIGNED(1)) dut_s (
    .clk(clk), .rst(rst), .enable(s_enable), .mode(s_mode), .decimate_reg(s_dec),
    .avg_shift(s_shift), .in_data(s_in_data), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .out_data(s_out_data), .out_valid(s_out_valid), .out_ready(s_out_ready), .sat_flag(s_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    u_enable = 1'b1; u_mode = 1'b0; u_dec = 32'd3; u_shift = 5'd0;
    u_in_data = 24'd0; u_in_valid = 1'b0; u_out_ready = 1'b1;
    s_enable = 1'b1; s_mode = 1'b1; s_dec = 32'd1; s_shift = 5'd0;
    s_in_data = 24'd0; s_in_valid = 1'b0; s_out_ready = 1'b1;

    // reset state
    step(); step();
    chk("rst_out_valid", u_out_valid, 1'b0);
    chk("rst_out_data", u_out_data, 32'd0);
    chk("rst_sat", u_sat, 1'b0);
    chk("rst_in_ready", u_in_ready, 1'b0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", u_in_ready, 1'b1);

    // pick mode, R=4, ramp
    for (int i = 0; i < 12; i++) begin
      u_in_data = {12'(i + 100), 12'(i)};
      u_in_valid = 1'b1;
      #1;
      chk("pick_in_ready", u_in_ready, 1'b1);
      step();
      chk("pick_out_valid", u_out_valid, ((i % 4) == 3) ? 1'b1 : 1'b0);
      if ((i % 4) == 3) chk("pick_out_data", u_out_data, {16'(i + 100), 16'(i)});
    end
    u_in_valid = 1'b0;
    step();
    chk("pick_drain", u_out_valid, 1'b0);

    // average mode, R=4, shift 2, unsigned
    u_mode = 1'b1; u_dec = 32'd3; u_shift = 5'd2;
    for (int i = 0; i < 4; i++) begin
      u_in_data = {12'd4095, 12'(10 * (i + 1))};
      u_in_valid = 1'b1;
      step();
      if (i < 3) chk("avg_early_valid", u_out_valid, 1'b0);
    end
    chk("avg_out_valid", u_out_valid, 1'b1);
    chk("avg_out_data", u_out_data, 32'h0FFF_0019);
    chk("avg_sat", u_sat, 1'b0);
    u_in_valid = 1'b0;
    step();

    // signed average with saturation, then arithmetic shift
    s_in_data = 24'h7FF7FF; s_in_valid = 1'b1;
    step();
    chk("s_first_valid", s_out_valid, 1'b0);
    step();
    chk("s_pos_valid", s_out_valid, 1'b1);
    chk("s_pos_data", s_out_data, 24'h7FF7FF);
    chk("s_pos_sat", s_sat, 1'b1);
    s_in_data = 24'h800800;
    step(); step();
    chk("s_neg_data", s_out_data, 24'h800800);
    chk("s_sat_sticky", s_sat, 1'b1);
    s_shift = 5'd1;
    s_in_data = {12'hFFD, 12'd5};
    step();
    s_in_data = {12'hFFC, 12'd6};
    step();
    chk("s_shift_data", s_out_data, 24'hFFC005);
    s_in_valid = 1'b0; s_enable = 1'b0;
    #1;
    chk("s_dis_in_ready", s_in_ready, 1'b0);
    step();
    chk("s_dis_sat_clear", s_sat, 1'b0);
    s_enable = 1'b1;

    // backpressure, R=1 pick
    u_mode = 1'b0; u_dec = 32'd0; u_shift = 5'd0;
    u_in_data = 24'h201101; u_in_valid = 1'b1; u_out_ready = 1'b1;
    #1; chk("bp_a_in_ready", u_in_ready, 1'b1);
    step();
    chk("bp_a_valid", u_out_valid, 1'b1);
    chk("bp_a_data", u_out_data, 32'h0201_0101);
    u_in_data = 24'h202102; u_out_ready = 1'b0;
    #1; chk("bp_b_in_ready", u_in_ready, 1'b0);
    step();
    chk("bp_b_data", u_out_data, 32'h0201_0101);
    #1; chk("bp_c_in_ready", u_in_ready, 1'b0);
    step();
    chk("bp_c_valid", u_out_valid, 1'b1);
    chk("bp_c_data", u_out_data, 32'h0201_0101);
    u_out_ready = 1'b1;
    #1; chk("bp_d_in_ready", u_in_ready, 1'b1);
    step();
    chk("bp_d_data", u_out_data, 32'h0202_0102);
    u_in_data = 24'h203103;
    step();
    chk("bp_e_data", u_out_data, 32'h0203_0103);
    u_in_valid = 1'b0;
    step();
    chk("bp_f_valid", u_out_valid, 1'b0);

    // ratio change mid-window: current window keeps R=4, next ones use R=2
    u_dec = 32'd3;
    exp_ov = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 8; i++) begin
      if (i == 2) u_dec = 32'd1;
      u_in_data = {12'd0, 12'(50 + i)};
      u_in_valid = 1'b1;
      step();
      chk("rc_valid", u_out_valid, exp_ov[i]);
      if (exp_ov[i]) chk("rc_data", u_out_data, {16'd0, 16'(50 + i)});
    end
    u_in_valid = 1'b0;
    step();

    // reset in mid-window
    u_dec = 32'd3;
    u_in_data = {12'd0, 12'd200}; u_in_valid = 1'b1;
    step();
    u_in_data = {12'd0, 12'd201};
    step();
    u_in_valid = 1'b0; rst = 1'b1;
    #1;
    chk("mr_valid", u_out_valid, 1'b0);
    chk("mr_in_ready", u_in_ready, 1'b0);
    chk("mr_data", u_out_data, 32'd0);
    step();
    chk("mr_valid_hold", u_out_valid, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      u_in_data = {12'd0, 12'(300 + i)};
      u_in_valid = 1'b1;
      step();
      chk("mr_post_valid", u_out_valid, (i == 3) ? 1'b1 : 1'b0);
    end
    chk("mr_post_data", u_out_data, 32'd303);
    u_in_valid = 1'b0;
    step();
    chk("mr_single", u_out_valid, 1'b0);

    // enable low flushes the partial window
    u_in_data = {12'd0, 12'd400}; u_in_valid = 1'b1;
    step();
    u_in_data = {12'd0, 12'd401};
    step();
    u_enable = 1'b0;
    #1;
    chk("en_in_ready", u_in_ready, 1'b0);
    step();
    u_enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      u_in_data = {12'd0, 12'(410 + i)};
      step();
      chk("en_valid", u_out_valid, (i == 3) ? 1'b1 : 1'b0);
    end
    chk("en_data", u_out_data, 32'd413);
    u_in_valid = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
